dataframe_store_forward: RTL and testbench

- Store-and-forward frame buffer directly downstream of the data-frame generator: consumes its `M_AXIS_TDATA`/`M_AXIS_TVALID`/`M_AXIS_TLAST` stream.
- Releases a frame to the output only after its TLAST beat has been written.
- Never back-pressures the generator. A frame that cannot fit is discarded whole and counted, so downstream DMA only ever sees complete frames.

---
 rtl/dataframe_buffer_pkg.sv | 24 ++
 rtl/dataframe_store_forward_sdp_bram.sv | 32 +++
 rtl/dataframe_store_forward.sv | 153 +++++++++++++++
 tb/tb_dataframe_store_forward.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataframe_buffer_pkg.sv
// Shared types and constants for the store-and-forward frame buffer.
// The beat width comes from the RFDC data-frame generator output.
`ifndef RFDC_TDATA_WIDTH
`define RFDC_TDATA_WIDTH 128
`endif

package dataframe_buffer_pkg;

    localparam int TDATA_WIDTH   = `RFDC_TDATA_WIDTH;
    localparam int DEFAULT_DEPTH = 512;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wr_state_e;

    // One extra bit so that full and empty differ when the addresses match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dataframe_store_forward_sdp_bram.sv
// Simple dual-port RAM: one write port, one registered read port with enable,
// written so that synthesis maps it onto block RAM.
module sdp_bram #(
    parameter int DATA_WIDTH = 129,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: memory and read register carry no reset; a reset would block
    // block-RAM inference, and the top gates rd_data with its valid flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dataframe_store_forward.sv
// Store-and-forward frame buffer: a frame is released only once its TLAST beat
// is stored; frames that do not fit are discarded whole and counted.
module dataframe_store_forward
    import dataframe_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = TDATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_W
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic [CNT_WIDTH-1:0]  FRAME_COUNT,
    output logic [CNT_WIDTH-1:0]  DROP_COUNT,
    output logic                  OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    wr_state_e state, state_next;

    logic [PW-1:0] wr_ptr, wr_ptr_next;
    logic [PW-1:0] commit_ptr, commit_ptr_next;
    logic [PW-1:0] rd_ptr;

    logic s_ready, accept, full;
    logic mem_we, frame_inc, drop_inc, overflow_set;
    logic rd_en, out_valid, overflow_q;
    logic [DATA_WIDTH:0] rd_word;
    logic [CNT_WIDTH-1:0] frame_count, drop_count;

    assign accept = S_AXIS_TVALID & s_ready;
    assign full   = (wr_ptr - rd_ptr) == DEPTH_P;

    // NOTE: every signal driven here gets a default first, so no latches.
    always_comb begin
        state_next      = state;
        wr_ptr_next     = wr_ptr;
        commit_ptr_next = commit_ptr;
        mem_we          = 1'b0;
        frame_inc       = 1'b0;
        drop_inc        = 1'b0;
        overflow_set    = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE, WRITE: begin
                    if (!full) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + ONE_P;
                        if (S_AXIS_TLAST) begin
                            commit_ptr_next = wr_ptr + ONE_P;
                            frame_inc       = 1'b1;
                            state_next      = IDLE;
                        end else begin
                            state_next = WRITE;
                        end
                    end else begin
                        // Rewind over the partial frame and drop its remainder.
                        wr_ptr_next  = commit_ptr;
                        overflow_set = 1'b1;
                        if (S_AXIS_TLAST) begin
                            drop_inc   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (S_AXIS_TLAST) begin
                        drop_inc   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            s_ready     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            commit_ptr <= commit_ptr_next;
            s_ready    <= 1'b1;
            overflow_q <= overflow_set;
            if (frame_inc) begin
                frame_count <= frame_count + 1'b1;
            end
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // The RAM read register doubles as the output data register.
    assign rd_en = (rd_ptr != commit_ptr) && (!out_valid || M_AXIS_TREADY);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr    <= rd_ptr + ONE_P;
                out_valid <= 1'b1;
            end else if (M_AXIS_TREADY) begin
                out_valid <= 1'b0;
            end
        end
    end

    sdp_bram #(
        .DATA_WIDTH (DATA_WIDTH + 1),
        .ADDR_WIDTH (AW)
    ) u_bram (
        .clk     (ACLK),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_word)
    );

    assign S_AXIS_TREADY = s_ready;
    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = out_valid ? rd_word[DATA_WIDTH-1:0] : '0;
    assign M_AXIS_TLAST  = out_valid & rd_word[DATA_WIDTH];
    assign FRAME_COUNT   = frame_count;
    assign DROP_COUNT    = drop_count;
    assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_dataframe_store_forward.sv
// Scoreboard bench for dataframe_store_forward: frames expected to survive are
// queued at issue time and a negedge monitor pops them on each output handshake.
module tb_dataframe_store_forward;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          S_AXIS_TVALID = 1'b0;
    logic          S_AXIS_TLAST = 1'b0;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TREADY = 1'b1;
    logic [CW-1:0] FRAME_COUNT;
    logic [CW-1:0] DROP_COUNT;
    logic          OVERFLOW;

    dataframe_store_forward #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .FRAME_COUNT   (FRAME_COUNT),
        .DROP_COUNT    (DROP_COUNT),
        .OVERFLOW      (OVERFLOW)
    );

    always #5 ACLK = ~ACLK;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    int    out_beats = 0;
    int    ovf_count = 0;
    int    first_valid_cyc = -1;
    int    last_hs_cyc = -1;
    int    last_tlast_cyc = 0;
    int    frame_exp = 0;
    int    drop_exp = 0;
    bit    rand_ready = 1'b0;

    always @(posedge ACLK) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops and compares on every handshake, checks stability under stall.
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        beat_t         b;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                prev_stall = 1'b0;
            end else begin
                if (first_valid_cyc < 0 && M_AXIS_TVALID) first_valid_cyc = cyc;
                if (OVERFLOW) ovf_count++;
                if (prev_stall) begin
                    check("stall_valid", M_AXIS_TVALID, 1);
                    check("stall_data", M_AXIS_TDATA, prev_data);
                    check("stall_last", M_AXIS_TLAST, prev_last);
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    out_beats++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got data %0h, expected no output (cycle %0d)", M_AXIS_TDATA, cyc);
                    end else begin
                        b = exp_q.pop_front();
                        check("out_data", M_AXIS_TDATA, b.data);
                        check("out_last", M_AXIS_TLAST, b.last);
                        if (M_AXIS_TLAST) last_hs_cyc = cyc;
                    end
                end
                prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
                prev_data  = M_AXIS_TDATA;
                prev_last  = M_AXIS_TLAST;
            end
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #2;
            if (rand_ready) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    // Drives one frame back-to-back; queues it as expected output when it must survive.
    task automatic send_frame(input int len, input bit keep, input bit counting, input logic [DW-1:0] base);
        logic [DW-1:0] d[$];
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (counting) d.push_back(base + DW'(i));
            else d.push_back({$urandom, $urandom, $urandom, $urandom});
        end
        if (keep) begin
            for (int i = 0; i < len; i++) begin
                b.data = d[i];
                b.last = (i == len - 1);
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < len; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = d[i];
            S_AXIS_TLAST  = (i == len - 1);
            if (i == len - 1) last_tlast_cyc = cyc;
            @(posedge ACLK);
            #1;
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge ACLK);
            g++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_count"}, FRAME_COUNT, frame_exp);
        check({tag, "_drop_count"}, DROP_COUNT, drop_exp);
    endtask

    initial begin
        int ovf0, out0, g;
        #1;
        check("rst_s_tready", S_AXIS_TREADY, 0);
        check("rst_m_tvalid", M_AXIS_TVALID, 0);
        check("rst_m_tdata", M_AXIS_TDATA, 0);
        check("rst_m_tlast", M_AXIS_TLAST, 0);
        check("rst_overflow", OVERFLOW, 0);
        check_counts("rst");
        idle(3);
        ARESET = 1'b0;
        #1;
        check("tready_before_edge", S_AXIS_TREADY, 0);
        @(posedge ACLK);
        #1;
        check("tready_after_edge", S_AXIS_TREADY, 1);

        // 1: four-beat frame, latency and one beat per cycle throughput.
        first_valid_cyc = -1;
        send_frame(4, 1'b1, 1'b1, 1);
        frame_exp++;
        drain("t1_drain");
        check("t1_latency", first_valid_cyc - last_tlast_cyc, 2);
        check("t1_throughput", last_hs_cyc - first_valid_cyc, 3);
        check_counts("t1");

        // 2: single-beat frame.
        send_frame(1, 1'b1, 1'b1, 'hAA);
        frame_exp++;
        drain("t2_drain");
        check_counts("t2");

        // 3: stalled sink, second frame cannot fit.
        M_AXIS_TREADY = 1'b0;
        ovf0 = ovf_count;
        out0 = out_beats;
        send_frame(10, 1'b1, 1'b0, '0);
        frame_exp++;
        send_frame(8, 1'b0, 1'b0, '0);
        drop_exp++;
        idle(4);
        check("t3_overflow_pulses", ovf_count - ovf0, 1);
        check_counts("t3");
        M_AXIS_TREADY = 1'b1;
        drain("t3_drain");
        idle(6);
        check("t3_beats_out", out_beats - out0, 10);

        // 4: frame longer than the buffer is dropped, next one survives.
        ovf0 = ovf_count;
        out0 = out_beats;
        send_frame(20, 1'b0, 1'b0, '0);
        drop_exp++;
        idle(8);
        check("t4_no_output", out_beats - out0, 0);
        check("t4_overflow_pulses", ovf_count - ovf0, 1);
        check_counts("t4_drop");
        send_frame(3, 1'b1, 1'b0, '0);
        frame_exp++;
        drain("t4_drain");
        check_counts("t4");

        // 5: random frames against a randomly stalling sink; a frame is only
        // issued when the beats still owed plus its length fit in the buffer.
        rand_ready = 1'b1;
        for (int f = 0; f < 50; f++) begin
            int len;
            len = $urandom_range(1, 8);
            g = 0;
            while (exp_q.size() + len > DEPTH && g < 1000) begin
                idle(1);
                g++;
            end
            if (g >= 1000) check("t5_pacing_timeout", exp_q.size(), 0);
            send_frame(len, 1'b1, 1'b0, '0);
            frame_exp++;
        end
        drain("t5_drain");
        rand_ready = 1'b0;
        M_AXIS_TREADY = 1'b1;
        idle(2);
        check_counts("t5");

        // 6: asynchronous reset mid-frame with a stalled output.
        M_AXIS_TREADY = 1'b0;
        send_frame(2, 1'b1, 1'b0, '0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = {$urandom, $urandom, $urandom, $urandom};
            S_AXIS_TLAST  = 1'b0;
            @(posedge ACLK);
            #1;
        end
        #2;
        ARESET = 1'b1;
        #1;
        exp_q.delete();
        frame_exp = 0;
        drop_exp = 0;
        S_AXIS_TVALID = 1'b0;
        check("t6_rst_m_tvalid", M_AXIS_TVALID, 0);
        check("t6_rst_m_tdata", M_AXIS_TDATA, 0);
        check("t6_rst_m_tlast", M_AXIS_TLAST, 0);
        check("t6_rst_s_tready", S_AXIS_TREADY, 0);
        check_counts("t6_rst");
        idle(2);
        ARESET = 1'b0;
        M_AXIS_TREADY = 1'b1;
        idle(1);
        check("t6_tready_back", S_AXIS_TREADY, 1);
        send_frame(5, 1'b1, 1'b0, '0);
        frame_exp++;
        drain("t6_drain");
        idle(4);
        check_counts("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
